// File: rtl/spart_pkg.sv
// Shared SPART receive-side types and default sizing.
package spart_pkg;

  localparam int unsigned RX_OVERSAMPLE_DEF = 16;
  localparam int unsigned RX_DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_ctrl_if.sv
// Handshake bundle between the rx sequencer, baud generator, shift register and bus side.
interface rx_ctrl_if;

  logic brg_en;
  logic rx_in;
  logic rd_ack;
  logic shift_en;
  logic rx_bit;
  logic busy;
  logic rda;
  logic framing_err;
  logic overrun;

  modport master (
    output brg_en, rx_in, rd_ack,
    input  shift_en, rx_bit, busy, rda, framing_err, overrun
  );

  modport slave (
    input  brg_en, rx_in, rd_ack,
    output shift_en, rx_bit, busy, rda, framing_err, overrun
  );

endinterface

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; RST_VAL sets the idle level.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx_ctrl.sv
// SPART receive sequencer: start detect, mid-bit shift strobes, stop check and status flags.
// Optional overrun detection is enabled by defining RX_OVERRUN_DET_EN.
module rx_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = RX_DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = RX_OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  rx_ctrl_if.slave   bus
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              busy_q, busy_d;
  logic              rda_q, rda_d;
  logic              ferr_q, ferr_d;
  logic              rx_bit;
  logic              shift_en_c;
  logic              frame_done_c;

  rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_in),
    .q   (rx_bit)
  );

  // Sequencer: all timing is counted in brg_en ticks; nothing moves between ticks.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_en_c   = 1'b0;
    frame_done_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.brg_en && !rx_bit) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (bus.brg_en) begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            if (!rx_bit) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (bus.brg_en) begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_en_c = 1'b1;
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (bus.brg_en) begin
          if (tick_cnt_q == TICK_LAST) begin
            frame_done_c = 1'b1;
            state_d      = IDLE;
            tick_cnt_d   = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A completing frame takes priority over a coincident read acknowledge.
  always_comb begin
    rda_d  = rda_q;
    ferr_d = ferr_q;
    if (bus.rd_ack && rda_q) begin
      rda_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (frame_done_c) begin
      rda_d  = 1'b1;
      ferr_d = ~rx_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      rda_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
      rda_q      <= rda_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef RX_OVERRUN_DET_EN
  logic ovr_q, ovr_d;

  // Sticky until acknowledged; a completion landing on the ack cycle is not an overrun.
  always_comb begin
    ovr_d = ovr_q;
    if (bus.rd_ack && rda_q) ovr_d = 1'b0;
    if (frame_done_c && rda_q && !bus.rd_ack) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovr_q <= 1'b0;
    else      ovr_q <= ovr_d;
  end

  assign bus.overrun = ovr_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.shift_en    = shift_en_c;
  assign bus.rx_bit      = rx_bit;
  assign bus.busy        = busy_q;
  assign bus.rda         = rda_q;
  assign bus.framing_err = ferr_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Scoreboard bench for rx_ctrl: tick-paced serial driver, reference flag model, decoupled monitor.
module tb_rx_ctrl;
  import spart_pkg::*;

  localparam int DB = int'(RX_DATA_BITS_DEF);
  localparam int OS = int'(RX_OVERSAMPLE_DEF);
`ifdef RX_OVERRUN_DET_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct packed {
    logic rda;
    logic fe;
    logic ov;
  } flags_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_ctrl_if bus ();

  rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_pass = 0;
  logic   exp_bits[$];
  flags_t exp_ev[$];
  flags_t m;
  flags_t e;
  logic   prev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples 2 time units before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        prev_busy = 1'b0;
      end else begin
        if (bus.shift_en) begin
          if (exp_bits.size() == 0) chk("unexpected_shift_en", 1, 0);
          else chk("rx_bit", int'(bus.rx_bit), int'(exp_bits.pop_front()));
        end
        if (prev_busy && !bus.busy) begin
          if (exp_ev.size() == 0) begin
            chk("unexpected_busy_fall", 1, 0);
          end else begin
            e = exp_ev.pop_front();
            chk("rda", int'(bus.rda), int'(e.rda));
            chk("framing_err", int'(bus.framing_err), int'(e.fe));
            chk("overrun", int'(bus.overrun), int'(e.ov));
            chk("shift_count", exp_bits.size(), 0);
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  // One oversample tick = 5 clocks, brg_en high on the last of them.
  task automatic tick(input logic ack);
    repeat (4) @(negedge clk);
    bus.brg_en = 1'b1;
    bus.rd_ack = ack;
    @(negedge clk);
    bus.brg_en = 1'b0;
    bus.rd_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic check_flags(input string tag);
    #1;
    chk({tag, "_rda"}, int'(bus.rda), int'(m.rda));
    chk({tag, "_framing_err"}, int'(bus.framing_err), int'(m.fe));
    chk({tag, "_overrun"}, int'(bus.overrun), int'(m.ov));
  endtask

  task automatic do_ack();
    tick(1'b1);
    if (m.rda) m = '0;
    check_flags("after_ack");
  endtask

  task automatic glitch(input int len);
    exp_ev.push_back(m);
    bus.rx_in = 1'b0;
    idle(len);
    bus.rx_in = 1'b1;
    idle(12);
  endtask

  task automatic do_reset();
    bus.rx_in = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_shift_en", int'(bus.shift_en), 0);
    chk("rst_rx_bit", int'(bus.rx_bit), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rda", int'(bus.rda), 0);
    chk("rst_framing_err", int'(bus.framing_err), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    exp_bits.delete();
    exp_ev.delete();
    m = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives start, DB data bits LSB first and stop, each OS ticks; abort_k>0 resets after the k-th shift.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic ack_done,
                            input int abort_k);
    int     done_t;
    int     ti;
    logic   v;
    flags_t f;
    done_t = 1 + OS / 2 + OS * (DB + 1);
    f.rda  = 1'b1;
    f.fe   = ~stop;
    f.ov   = OVR_EN && !ack_done && (m.ov || m.rda);
    for (int i = 0; i < DB; i++) exp_bits.push_back(data[i]);
    exp_ev.push_back(f);
    // A low stop bit still on the line is seen as a new start, then rejected as a glitch.
    if (!stop) exp_ev.push_back(f);
    for (int b = 0; b < DB + 2; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= DB) v = data[b-1];
      else v = stop;
      bus.rx_in = v;
      for (int t = 0; t < OS; t++) begin
        ti = b * OS + t + 1;
        tick(ack_done && (ti == done_t));
        if (abort_k > 0 && ti == 1 + OS / 2 + OS * abort_k) begin
          do_reset();
          return;
        end
      end
    end
    bus.rx_in = 1'b1;
    m = f;
    if (!stop) idle(12);
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    logic       a;
    bus.brg_en = 1'b0;
    bus.rx_in  = 1'b1;
    bus.rd_ack = 1'b0;
    m = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_shift_en", int'(bus.shift_en), 0);
    chk("reset_rx_bit", int'(bus.rx_bit), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_rda", int'(bus.rda), 0);
    chk("reset_framing_err", int'(bus.framing_err), 0);
    chk("reset_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(4);

    send_frame(8'h5A, 1'b1, 1'b0, 0);
    do_ack();
    glitch(4);
    check_flags("after_glitch");
    send_frame(8'h00, 1'b0, 1'b0, 0);
    do_ack();
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    check_flags("back_to_back");
    do_ack();
    send_frame(8'h33, 1'b1, 1'b0, 0);
    send_frame(8'hC4, 1'b1, 1'b1, 0);
    check_flags("ack_at_done");
    do_ack();
    send_frame(8'h96, 1'b1, 1'b0, 3);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    do_ack();

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) < 2) glitch(int'($urandom_range(1, 7)));
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 5) == 0);
      send_frame(d, s, a, 0);
      if ($urandom_range(0, 1) == 1) do_ack();
      idle(int'($urandom_range(0, 3)));
    end

    idle(12);
    chk("pending_shifts", exp_bits.size(), 0);
    chk("pending_frames", exp_ev.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
- Receive-side sequencer for the SPART.
- Synchronises the serial line and detects the start bit using the 16x baud-rate-generator enable (brg_en).
- Drives the shift-enable of the receive shift register at mid-bit for each data bit, checks the stop bit, and raises data-available and error flags for the bus interface.
- Sits between the baud-rate generator, the rx shift register and the SPART bus interface.

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first); legal 5..8.
- OVERSAMPLE, 16, brg_en ticks per bit period; legal even values 8..16.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- brg_en  input  1  one-clk-wide oversample tick from the baud-rate generator
- rx_in  input  1  raw asynchronous serial line (idle high)
- rd_ack  input  1  one-clk pulse: bus has read the receive buffer
- shift_en  output  1  one-clk pulse: shift rx_bit into the rx shift register
- rx_bit  output  1  synchronised line value presented with shift_en
- busy  output  1  frame in progress (state != IDLE)
- rda  output  1  receive data available
- framing_err  output  1  stop bit sampled low on the last frame
- overrun  output  1  frame completed while rda already set

Behaviour:
- Reset (rst low, async):
  - state=IDLE, tick_cnt=0, bit_cnt=0.
  - Synchroniser flops = 1.
  - All outputs 0 (rx_bit=1).
- Synchroniser:
  - Two flops on rx_in; rx_bit = second flop.
  - rx_in to rx_bit latency is 2 clk.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits and advances only on cycles with brg_en=1.
  - bit_cnt is $clog2(DATA_BITS+1) bits.
- IDLE:
  - On brg_en & rx_bit==0 -> START, tick_cnt=0.
  - Otherwise stay.
- START:
  - On brg_en: if tick_cnt==OVERSAMPLE/2-1, check rx_bit.
    - rx_bit==0 -> DATA, tick_cnt=0, bit_cnt=0.
    - rx_bit==1 -> IDLE (glitch rejected, no flags).
  - Otherwise tick_cnt++.
- DATA:
  - On brg_en: if tick_cnt==OVERSAMPLE-1:
    - shift_en=1 this same cycle (combinational from state, brg_en, tick_cnt).
    - tick_cnt=0, bit_cnt++.
    - If bit_cnt==DATA_BITS-1 -> STOP.
  - Otherwise tick_cnt++.
  - Exactly DATA_BITS shift_en pulses per accepted frame, each OVERSAMPLE brg_en ticks apart.
- STOP:
  - On brg_en with tick_cnt==OVERSAMPLE-1: sample the stop bit, go to IDLE, tick_cnt=0.
  - Same-edge register updates:
    - rda<=1.
    - framing_err<=~rx_bit.
  - Return to IDLE at mid-stop-bit allows back-to-back frames.
- Flags:
  - rd_ack clears rda, framing_err (and overrun) on the next edge.
  - If rd_ack coincides with a frame-complete set, the set wins.
  - rd_ack while rda=0 has no effect.
- shift_en is never asserted outside DATA.
- brg_en is ignored in every state except for counting; no activity between ticks.
- Reset mid-frame: immediate return to IDLE, no shift_en, flags cleared.

Optional Feature:
- Macro: RX_OVERRUN_DET_EN.
- Defined:
  - overrun<=1 when a frame completes while rda==1 (the old data is lost in the shift register).
  - overrun is sticky until rd_ack.
  - A completion coincident with rd_ack is not an overrun.
- Undefined: overrun is tied to 0; no additional flops.

Decomposition:
- spart_pkg holds:
  - rx state enum (IDLE, START, DATA, STOP), 2-bit encoding.
  - OVERSAMPLE default constant.
  - Default DATA_BITS.
- Sub-module rx_sync: 2-flop synchroniser with reset value 1, parameterised reset value. Instantiated once.
- The FSM, counters and flags stay in rx_ctrl.

Test Plan:
1. Common setup: brg_en high 1 clk in every 5, rx_in idle 1 after reset.
   - Send 0x5A (start 0, bits LSB-first, stop 1, each held 16 ticks).
   - Required: exactly 8 shift_en pulses with rx_bit sequence 0,1,0,1,1,0,1,0.
   - Required: rda=1 and framing_err=0 after the stop sample; busy low afterwards.
2. rx_in low for 4 ticks, then high.
   - Required: START entered then IDLE; 0 shift_en pulses; rda stays 0.
3. Frame 0x00 with stop bit driven 0.
   - Required: 8 shift_en pulses, all with rx_bit=0.
   - Required: rda=1, framing_err=1; rd_ack pulse -> both 0 next cycle.
4. Two back-to-back frames 0xFF, 0x81, no rd_ack between them.
   - Required: second frame still gives 8 pulses.
   - With RX_OVERRUN_DET_EN: overrun=1 after the second stop sample.
   - Without the macro: overrun stays 0.
5. rd_ack asserted on the exact cycle of stop-bit completion.
   - Required: rda remains 1; overrun not set.
6. rst driven low after the 3rd shift_en of a frame.
   - Required: asynchronously all outputs 0, busy=0.
   - After release: idle line gives no activity; next valid frame is received correctly.
